// File: rtl/modexp_ctrl_pkg.sv
// Shared types and constants for the modular-exponentiation sequencer.
// The state enum lives here so the parent and any monitors decode it identically.
package modexp_ctrl_pkg;

   localparam int WIDTH_DEF = 1024;
   localparam int EXP_W_DEF = 32;
   localparam int TLEN_W    = 6;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      TOMONT   = 3'd1,
      SQUARE   = 3'd2,
      MULT     = 3'd3,
      FROMMONT = 3'd4,
      DONE     = 3'd5
   } state_t;

   // States that issue exactly one Montgomery multiply and wait for its completion.
   function automatic logic is_mult_state(input state_t s);
      return (s == TOMONT) || (s == SQUARE) || (s == MULT) || (s == FROMMONT);
   endfunction

endpackage

// File: rtl/modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer computing x^t mod n in the Montgomery domain,
// driving an external Montgomery multiplier through a start/done handshake.
module modexp_ctrl
   import modexp_ctrl_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int EXP_W = EXP_W_DEF
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [WIDTH-1:0]  x,
   input  logic [WIDTH-1:0]  n,
   input  logic [WIDTH-1:0]  r_n,
   input  logic [WIDTH-1:0]  r2_n,
   input  logic [EXP_W-1:0]  t,
   input  logic [TLEN_W-1:0] t_len,
   output logic              busy,
   output logic              done,
   output logic [WIDTH-1:0]  result,
   output logic              mm_start,
   output logic [WIDTH-1:0]  mm_a,
   output logic [WIDTH-1:0]  mm_b,
   output logic [WIDTH-1:0]  mm_m,
   input  logic [WIDTH-1:0]  mm_result,
   input  logic              mm_done
);

   localparam int IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;

   state_t            state_reg, state_next;
   logic              first_reg, first_next;
   logic              mm_accept;
   logic [WIDTH-1:0]  x_reg;
   logic [EXP_W-1:0]  t_reg;
   logic [TLEN_W-1:0] len_reg;
   logic [IDX_W-1:0]  i_reg;
   logic [WIDTH-1:0]  a_reg;
   logic [WIDTH-1:0]  x_tilde_reg;
   logic [WIDTH-1:0]  result_reg;

   logic [TLEN_W-1:0] len_clip;
   logic [IDX_W-1:0]  idx_load;
   logic              bit_set;
   logic              last_bit;

   // Exponent lengths beyond the register width are clamped to the register width.
   always_comb begin
      len_clip = t_len;
      if (int'(t_len) > EXP_W) begin
         len_clip = TLEN_W'(EXP_W);
      end
      idx_load = IDX_W'(len_clip - TLEN_W'(1));
   end

   assign bit_set  = t_reg[i_reg];
   assign last_bit = (i_reg == '0);
   assign mm_m     = n;
   assign result   = result_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
         first_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         first_reg <= first_next;
      end
   end

   // first_reg marks the issue cycle of a multiply; completions are only
   // accepted after that, so a stale mm_done cannot complete a fresh request.
   always_comb begin
      state_next = state_reg;
      busy       = (state_reg != IDLE);
      done       = 1'b0;
      mm_start   = is_mult_state(state_reg) && first_reg;
      mm_accept  = is_mult_state(state_reg) && !first_reg && mm_done;
      mm_a       = '0;
      mm_b       = '0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next = TOMONT;
            end
         end
         TOMONT: begin
            mm_a = x_reg;
            mm_b = r2_n;
            if (mm_accept) begin
               state_next = (len_reg != '0) ? SQUARE : FROMMONT;
            end
         end
         SQUARE: begin
            mm_a = a_reg;
            mm_b = a_reg;
            if (mm_accept) begin
               if (bit_set) begin
                  state_next = MULT;
               end else if (last_bit) begin
                  state_next = FROMMONT;
               end else begin
                  state_next = SQUARE;
               end
            end
         end
         MULT: begin
            mm_a = a_reg;
            mm_b = x_tilde_reg;
            if (mm_accept) begin
               state_next = last_bit ? FROMMONT : SQUARE;
            end
         end
         FROMMONT: begin
            mm_a = a_reg;
            mm_b = WIDTH'(1);
            if (mm_accept) begin
               state_next = DONE;
            end
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
      first_next = is_mult_state(state_next) && (mm_accept || (state_reg == IDLE));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x_reg       <= '0;
         t_reg       <= '0;
         len_reg     <= '0;
         i_reg       <= '0;
         a_reg       <= '0;
         x_tilde_reg <= '0;
         result_reg  <= '0;
      end else begin
         if ((state_reg == IDLE) && start) begin
            x_reg   <= x;
            t_reg   <= t;
            len_reg <= len_clip;
            i_reg   <= idx_load;
            a_reg   <= r_n;
         end
         if (mm_accept) begin
            case (state_reg)
               TOMONT: begin
                  x_tilde_reg <= mm_result;
               end
               SQUARE: begin
                  a_reg <= mm_result;
                  if (!bit_set && !last_bit) begin
                     i_reg <= i_reg - IDX_W'(1);
                  end
               end
               MULT: begin
                  a_reg <= mm_result;
                  if (!last_bit) begin
                     i_reg <= i_reg - IDX_W'(1);
                  end
               end
               FROMMONT: begin
                  result_reg <= mm_result;
               end
               default: begin
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_modexp_ctrl.sv
// Self-checking bench: behavioural Montgomery multiplier with random latency plus a
// plain modular-power reference for results and multiply counts.
module tb_modexp_ctrl;
   import modexp_ctrl_pkg::*;

   localparam int WIDTH = 32;
   localparam int EXP_W = 32;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic [WIDTH-1:0]  x, n, r_n, r2_n;
   logic [EXP_W-1:0]  t;
   logic [TLEN_W-1:0] t_len;
   logic              busy, done;
   logic [WIDTH-1:0]  result;
   logic              mm_start;
   logic [WIDTH-1:0]  mm_a, mm_b, mm_m, mm_result;
   logic              mm_done;

   logic              model_done = 1'b0;
   logic [WIDTH-1:0]  model_result = '0;
   logic              model_pending = 1'b0;
   int                lat_cnt = 0;
   logic [WIDTH-1:0]  lat_a = '0, lat_b = '0, lat_m = '0;
   logic              stray_done;

   int checks = 0;
   int failures = 0;
   int lat_lo = 1;
   int lat_hi = 20;

   int start_cnt = 0, done_cnt = 0, stab_err = 0, proto_err = 0, mmm_err = 0, busy_err = 0;

   always #5 clk = ~clk;

   assign mm_done   = model_done | stray_done;
   assign mm_result = stray_done ? 32'hDEADBEEF : model_result;

   modexp_ctrl #(.WIDTH(WIDTH), .EXP_W(EXP_W)) dut (
      .clk(clk), .reset(reset), .start(start),
      .x(x), .n(n), .r_n(r_n), .r2_n(r2_n), .t(t), .t_len(t_len),
      .busy(busy), .done(done), .result(result),
      .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_m(mm_m),
      .mm_result(mm_result), .mm_done(mm_done)
   );

   // a*b*2^-WIDTH mod m, by halving modulo an odd m
   function automatic longint unsigned mont(input longint unsigned a, input longint unsigned b,
                                            input longint unsigned m);
      longint unsigned p;
      p = ((a % m) * (b % m)) % m;
      for (int k = 0; k < WIDTH; k++) begin
         p = p[0] ? ((p + m) >> 1) : (p >> 1);
      end
      return p;
   endfunction

   function automatic longint unsigned ref_pow(input longint unsigned xb, input longint unsigned e,
                                               input int len, input longint unsigned m);
      longint unsigned r, b;
      r = 1 % m;
      b = xb % m;
      for (int k = 0; k < len; k++) begin
         if (e[k]) r = (r * b) % m;
         b = (b * b) % m;
      end
      return r;
   endfunction

   function automatic int ref_mults(input longint unsigned e, input int len);
      int c;
      c = 2 + len;
      for (int k = 0; k < len; k++) begin
         if (e[k]) c++;
      end
      return c;
   endfunction

   function automatic int eff_len(input int li);
      return (li > EXP_W) ? EXP_W : li;
   endfunction

   always @(posedge clk) begin
      model_done <= 1'b0;
      if (reset) begin
         model_pending <= 1'b0;
      end else if (model_pending) begin
         if (lat_cnt <= 1) begin
            model_done    <= 1'b1;
            model_result  <= WIDTH'(mont(lat_a, lat_b, lat_m));
            model_pending <= 1'b0;
         end else begin
            lat_cnt <= lat_cnt - 1;
         end
      end else if (mm_start) begin
         model_pending <= 1'b1;
         lat_cnt       <= int'($urandom_range(lat_hi, lat_lo));
         lat_a         <= mm_a;
         lat_b         <= mm_b;
         lat_m         <= mm_m;
      end
   end

   always @(negedge clk) begin
      if (mm_start) begin
         start_cnt++;
         if (model_pending) proto_err++;
      end
      if (done) done_cnt++;
      if (model_pending && (mm_a !== lat_a || mm_b !== lat_b)) stab_err++;
      if (mm_m !== n) mmm_err++;
      if (model_pending && !busy) busy_err++;
   end

   task automatic set_mod(input logic [WIDTH-1:0] ni);
      longint unsigned rn;
      rn   = 64'h1_0000_0000 % longint'(ni);
      n    = ni;
      r_n  = WIDTH'(rn);
      r2_n = WIDTH'((rn * rn) % longint'(ni));
   endtask

   task automatic run_op(input logic [WIDTH-1:0] xi, input logic [EXP_W-1:0] ti,
                         input logic [TLEN_W-1:0] li, input logic [WIDTH-1:0] ni, input bit hold,
                         output logic [WIDTH-1:0] res, output int mults, output int dones,
                         output bit timed_out);
      int s0, d0;
      @(negedge clk);
      x = xi; t = ti; t_len = li;
      set_mod(ni);
      #1;
      s0 = start_cnt;
      d0 = done_cnt;
      start = 1'b1;
      timed_out = 1'b1;
      for (int cyc = 0; cyc < 20000; cyc++) begin
         @(negedge clk);
         if (!hold) start = 1'b0;
         else if (cyc == 20) start = 1'b0;
         else if (cyc == 21) start = 1'b1;
         if (done) begin
            timed_out = 1'b0;
            break;
         end
      end
      start = 1'b0;
      res = result;
      #1;
      mults = start_cnt - s0;
      dones = done_cnt - d0;
      $display("op x=%0d t=%h t_len=%0d n=%0d -> result=%0d mults=%0d dones=%0d timeout=%0d",
               xi, ti, li, ni, res, mults, dones, timed_out);
   endtask

   task automatic test_reset();
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
      checks++; if (mm_start !== 1'b0) begin failures++; $display("FAIL reset_mm_start got=%b want=0", mm_start); end
      checks++; if (result !== '0) begin failures++; $display("FAIL reset_result got=%0d want=0", result); end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_directed();
      logic [WIDTH-1:0] res; int mults, dones; bit to;
      lat_lo = 1; lat_hi = 50;
      run_op(32'd7, 32'd5, 6'd3, 32'd13, 1'b0, res, mults, dones, to);
      checks++; if (to) begin failures++; $display("FAIL dir_timeout got=1 want=0"); end
      checks++; if (res !== 32'd11) begin failures++; $display("FAIL dir_result got=%0d want=11", res); end
      checks++; if (mults != 7) begin failures++; $display("FAIL dir_mults got=%0d want=7", mults); end
      checks++; if (dones != 1) begin failures++; $display("FAIL dir_dones got=%0d want=1", dones); end
      @(negedge clk);
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin
         failures++; $display("FAIL dir_after got done=%b busy=%b want 0 0", done, busy);
      end
   endtask

   task automatic test_tlen_zero();
      logic [WIDTH-1:0] res; int mults, dones; bit to;
      run_op($urandom, $urandom, 6'd0, 32'd1000003, 1'b0, res, mults, dones, to);
      checks++; if (to) begin failures++; $display("FAIL tlen0_timeout got=1 want=0"); end
      checks++; if (res !== 32'd1) begin failures++; $display("FAIL tlen0_result got=%0d want=1", res); end
      checks++; if (mults != 2) begin failures++; $display("FAIL tlen0_mults got=%0d want=2", mults); end
   endtask

   task automatic test_all_ones();
      logic [WIDTH-1:0] res; int mults, dones; bit to; longint unsigned exp_r;
      exp_r = ref_pow(2, 32'hFFFFFFFF, 32, 1000003);
      run_op(32'd2, 32'hFFFFFFFF, 6'd32, 32'd1000003, 1'b0, res, mults, dones, to);
      checks++; if (to) begin failures++; $display("FAIL ones_timeout got=1 want=0"); end
      checks++; if (res !== WIDTH'(exp_r)) begin failures++; $display("FAIL ones_result got=%0d want=%0d", res, exp_r); end
      checks++; if (mults != 66) begin failures++; $display("FAIL ones_mults got=%0d want=66", mults); end
   endtask

   task automatic test_tlen_clip();
      logic [WIDTH-1:0] res, xi, ni; logic [EXP_W-1:0] ti; int mults, dones; bit to;
      longint unsigned exp_r; int exp_m;
      xi = $urandom; ti = $urandom; ni = $urandom_range(32'h7FFFFFFF, 3) | 32'd1;
      exp_r = ref_pow(xi, ti, eff_len(40), ni);
      exp_m = ref_mults(ti, eff_len(40));
      run_op(xi, ti, 6'd40, ni, 1'b0, res, mults, dones, to);
      checks++; if (to) begin failures++; $display("FAIL clip_timeout got=1 want=0"); end
      checks++; if (res !== WIDTH'(exp_r)) begin failures++; $display("FAIL clip_result got=%0d want=%0d", res, exp_r); end
      checks++; if (mults != exp_m) begin failures++; $display("FAIL clip_mults got=%0d want=%0d", mults, exp_m); end
   endtask

   task automatic test_start_hold();
      logic [WIDTH-1:0] res; int mults, dones; bit to; longint unsigned exp_r;
      exp_r = ref_pow(3, 32'hFFFFFFFF, 32, 1000003);
      run_op(32'd3, 32'hFFFFFFFF, 6'd32, 32'd1000003, 1'b1, res, mults, dones, to);
      checks++; if (res !== WIDTH'(exp_r)) begin failures++; $display("FAIL hold_result got=%0d want=%0d", res, exp_r); end
      checks++; if (mults != 66) begin failures++; $display("FAIL hold_mults got=%0d want=66", mults); end
      checks++; if (dones != 1) begin failures++; $display("FAIL hold_dones got=%0d want=1", dones); end
      repeat (2) @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL hold_restart got busy=%b want=0", busy); end
   endtask

   task automatic test_reset_mid();
      logic [WIDTH-1:0] res; int mults, dones, seen, s0; bit to;
      lat_lo = 60; lat_hi = 60;
      @(negedge clk);
      x = 32'd7; t = 32'd5; t_len = 6'd3;
      set_mod(32'd13);
      start = 1'b1;
      seen = 0;
      for (int g = 0; g < 500; g++) begin
         @(negedge clk);
         start = 1'b0;
         if (mm_start) seen++;
         if (seen == 2) break;
      end
      checks++; if (seen != 2) begin failures++; $display("FAIL rstmid_reach_square got=%0d want=2", seen); end
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b want=0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL rstmid_done got=%b want=0", done); end
      checks++; if (mm_start !== 1'b0) begin failures++; $display("FAIL rstmid_mm_start got=%b want=0", mm_start); end
      checks++; if (result !== '0) begin failures++; $display("FAIL rstmid_result got=%0d want=0", result); end
      s0 = start_cnt;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      @(negedge clk);
      stray_done = 1'b1;
      @(negedge clk);
      stray_done = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_stray_busy got=%b want=0", busy); end
      checks++; if (start_cnt != s0) begin failures++; $display("FAIL rstmid_stray_starts got=%0d want=0", start_cnt - s0); end
      lat_lo = 1; lat_hi = 50;
      run_op(32'd7, 32'd5, 6'd3, 32'd13, 1'b0, res, mults, dones, to);
      checks++; if (to) begin failures++; $display("FAIL rstmid_next_timeout got=1 want=0"); end
      checks++; if (res !== 32'd11) begin failures++; $display("FAIL rstmid_next_result got=%0d want=11", res); end
      checks++; if (mults != 7) begin failures++; $display("FAIL rstmid_next_mults got=%0d want=7", mults); end
   endtask

   task automatic test_random();
      logic [WIDTH-1:0] res, xi, ni; logic [EXP_W-1:0] ti; logic [TLEN_W-1:0] li;
      int mults, dones, exp_m; bit to; longint unsigned exp_r;
      lat_lo = 1; lat_hi = 20;
      for (int k = 0; k < 10; k++) begin
         xi = $urandom; ti = $urandom; li = TLEN_W'($urandom_range(40, 0));
         ni = $urandom_range(32'h7FFFFFFF, 3) | 32'd1;
         exp_r = ref_pow(xi, ti, eff_len(int'(li)), ni);
         exp_m = ref_mults(ti, eff_len(int'(li)));
         run_op(xi, ti, li, ni, 1'b0, res, mults, dones, to);
         checks++; if (res !== WIDTH'(exp_r)) begin failures++; $display("FAIL rand_result[%0d] got=%0d want=%0d", k, res, exp_r); end
         checks++; if (mults != exp_m) begin failures++; $display("FAIL rand_mults[%0d] got=%0d want=%0d", k, mults, exp_m); end
         checks++; if (dones != 1) begin failures++; $display("FAIL rand_dones[%0d] got=%0d want=1", k, dones); end
      end
   endtask

   task automatic test_back_to_back();
      logic [WIDTH-1:0] res, xi; logic [EXP_W-1:0] ti; int mults, dones; bit to; longint unsigned exp_r;
      lat_lo = 1; lat_hi = 3;
      for (int k = 0; k < 3; k++) begin
         xi = $urandom; ti = $urandom;
         exp_r = ref_pow(xi, ti, 16, 1000003);
         run_op(xi, ti, 6'd16, 32'd1000003, 1'b0, res, mults, dones, to);
         checks++; if (res !== WIDTH'(exp_r)) begin failures++; $display("FAIL b2b_result[%0d] got=%0d want=%0d", k, res, exp_r); end
         checks++; if (mults != ref_mults(ti, 16)) begin failures++; $display("FAIL b2b_mults[%0d] got=%0d want=%0d", k, mults, ref_mults(ti, 16)); end
      end
   endtask

   task automatic test_idle_done();
      int s0;
      repeat (2) @(negedge clk);
      #1 s0 = start_cnt;
      stray_done = 1'b1;
      @(negedge clk);
      stray_done = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_done_busy got=%b want=0", busy); end
      checks++; if (start_cnt != s0) begin failures++; $display("FAIL idle_done_starts got=%0d want=0", start_cnt - s0); end
   endtask

   task automatic test_protocol();
      #1;
      checks++; if (stab_err != 0) begin failures++; $display("FAIL proto_operand_stability got=%0d want=0", stab_err); end
      checks++; if (proto_err != 0) begin failures++; $display("FAIL proto_start_pulse got=%0d want=0", proto_err); end
      checks++; if (mmm_err != 0) begin failures++; $display("FAIL proto_mm_m got=%0d want=0", mmm_err); end
      checks++; if (busy_err != 0) begin failures++; $display("FAIL proto_busy got=%0d want=0", busy_err); end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; stray_done = 1'b0;
      x = '0; t = '0; t_len = '0;
      set_mod(32'd13);
      repeat (3) @(negedge clk);
      test_reset();
      test_directed();
      test_tlen_zero();
      test_all_ones();
      test_tlen_clip();
      test_start_hold();
      test_reset_mid();
      test_idle_done();
      test_random();
      test_back_to_back();
      test_protocol();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
